fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32 core. It holds the program counter and drives the instruction-memory address. It applies branch/jump redirects from Execute and latches the fetched instruction into Decode. It consumes the hazard unit's StallF, StallD and FlushD, plus PCSrcE and PCTargetE from Execute.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and data paths
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) injected on flush/reset

Ports:
clk  input  1  core clock, all state updates on rising edge
rstn  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  global enable; 0 freezes all state
StallF  input  1  hold PCF
StallD  input  1  hold IF/ID register
FlushD  input  1  bubble IF/ID register
PCSrcE  input  1  redirect PC to PCTargetE
PCTargetE  input  DATA_WIDTH  redirect target from Execute
imem_addr  output  DATA_WIDTH  instruction-memory address, equals PCF (combinational)
imem_rdata  input  DATA_WIDTH  instruction at imem_addr, valid same cycle (asynchronous-read memory)
PCF  output  DATA_WIDTH  current fetch PC (register)
InstrD  output  DATA_WIDTH  instruction in Decode
PCD  output  DATA_WIDTH  PC of InstrD
PCPlus4D  output  DATA_WIDTH  PCD+4
ValidD  output  1  1 = InstrD is a real fetched instruction, 0 = bubble
redirect_cnt  output  16  count of accepted redirects, saturating

Behaviour:
- Reset (rstn=0 at a rising edge) takes priority over everything, including en=0.
- Reset values: PCF=RESET_PC; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0; redirect_cnt=0.
- en=0 with rstn=1: every register holds. Stall, flush and redirect inputs are ignored that cycle.
- PCPlus4F = PCF+4, truncated to DATA_WIDTH. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- PC register update priority when en=1:
  - PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}. Redirect wins over StallF; the low two target bits are always cleared.
  - else StallF=1: PCF holds.
  - else PCF <= PCPlus4F.
- IF/ID register update priority when en=1:
  - FlushD=1: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0. Flush wins over StallD.
  - else StallD=1: all four hold.
  - else InstrD<=imem_rdata, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
- redirect_cnt increments by 1 on each en=1 edge with PCSrcE=1 and saturates at 16'hFFFF.
- Latency:
  - An instruction at PCF appears on InstrD one cycle later, absent stall or flush.
  - A redirect asserted in cycle N puts the target on PCF in cycle N+1 and on InstrD in cycle N+2.
- Load-use stall (StallF=StallD=1): PCF and the IF/ID contents both hold for exactly the stalled cycles, with no instruction lost or duplicated.
- StallF=1 with StallD=0 is legal. IF/ID recaptures the same PCF each cycle, and ValidD stays 1.
- imem_addr is purely combinational from PCF, with no extra cycle.

Test Plan:
- Reset and sequential fetch: rstn=0 for 2 cycles, then release with imem returning 32'h00A00093 at address 0 -> PCF=0, 4, 8 on successive cycles; InstrD=32'h00A00093, PCD=0, PCPlus4D=4, ValidD=1 one cycle after release.
- Load-use stall: at PCF=8, StallF=StallD=1 for 1 cycle -> PCF stays 8 and InstrD/PCD (=4) hold that cycle; next cycle PCF=12 and PCD=8, with no skipped or duplicated PC.
- Taken branch: PCSrcE=1, PCTargetE=32'h0000_0100, FlushD=1 in the same cycle -> next cycle PCF=32'h100, InstrD=NOP_INSTR, ValidD=0, redirect_cnt=1; following cycle PCD=32'h100, ValidD=1.
- Priority conflicts: PCSrcE=1 with StallF=1, and FlushD=1 with StallD=1, target 32'h0000_0203 -> PCF=32'h200 (low bits cleared), IF/ID bubbled.
- Enable and mid-run reset: en=0 for 3 cycles with PCSrcE=1 -> no state change and redirect_cnt unchanged; then rstn=0 while PCF=32'h40 and StallD=1 -> PCF=RESET_PC, ValidD=0 next edge.
- Wrap and saturation: preload PCF=32'hFFFF_FFFC via redirect -> next PCF=0; hold PCSrcE=1 for 65540 cycles -> redirect_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage RV32 core: program counter, redirect
// handling and the IF/ID pipeline register feeding Decode.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic [15:0]           redirect_cnt
);

  logic [DATA_WIDTH-1:0] pcPlus4F;
  logic [DATA_WIDTH-1:0] redirectPc;
  logic [DATA_WIDTH-1:0] pcNext;
  logic [15:0]           redirectCntNext;
  logic                  unusedTargetLsbs;

  // Addition wraps naturally at the top of the address space.
  assign pcPlus4F  = PCF + DATA_WIDTH'(4);
  assign imem_addr = PCF;

  // Targets are forced word-aligned; the dropped bits carry no information.
  assign redirectPc       = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
  assign unusedTargetLsbs = ^PCTargetE[1:0];

  always_comb begin
    pcNext = pcPlus4F;
    if (PCSrcE) begin
      pcNext = redirectPc;
    end else if (StallF) begin
      pcNext = PCF;
    end
  end

  assign redirectCntNext = (redirect_cnt == 16'hFFFF) ? redirect_cnt
                                                      : redirect_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      PCF <= RESET_PC;
    end else if (en) begin
      PCF <= pcNext;
    end
  end

  // Flush beats stall so a squashed slot never lingers in Decode.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (en) begin
      if (FlushD) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (!StallD) begin
        InstrD   <= imem_rdata;
        PCD      <= PCF;
        PCPlus4D <= pcPlus4F;
        ValidD   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      redirect_cnt <= 16'd0;
    end else if (en && PCSrcE) begin
      redirect_cnt <= redirectCntNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic        StallF = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic [15:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mPC = 32'h0;
  logic [31:0] mInstr = NOP;
  logic [31:0] mPCD = 32'h0;
  logic [31:0] mP4D = 32'h0;
  logic        mValid = 1'b0;
  logic [15:0] mCnt = 16'h0;

  logic [176:0] dutState;
  logic [176:0] expState;
  logic [176:0] savedState;

  fetch_stage #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en          (en),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .PCF         (PCF),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Asynchronous-read instruction memory
  assign imem_rdata = memWord(imem_addr);

  assign dutState = {imem_addr, PCF, InstrD, PCD, PCPlus4D, ValidD, redirect_cnt};
  assign expState = {mPC, mPC, mInstr, mPCD, mP4D, mValid, mCnt};

  // Advance one clock and apply the architectural rules to the model, then
  // settle so outputs are sampled 1 time unit after the edge.
  task automatic clockEdge();
    logic [31:0] seqPc;
    @(posedge clk);
    if (!rstn) begin
      mPC = 32'h0; mInstr = NOP; mPCD = 32'h0; mP4D = 32'h0; mValid = 1'b0; mCnt = 16'h0;
    end else if (en) begin
      seqPc = mPC + 32'd4;
      if (FlushD) begin
        mInstr = NOP; mPCD = 32'h0; mP4D = 32'h0; mValid = 1'b0;
      end else if (!StallD) begin
        mInstr = memWord(mPC); mPCD = mPC; mP4D = seqPc; mValid = 1'b1;
      end
      if (PCSrcE) mPC = PCTargetE & ~32'd3;
      else if (!StallF) mPC = seqPc;
      if (PCSrcE && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
    end
    #1;
  endtask

  task automatic clearCtl();
    en = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
  endtask

  task automatic test_reset();
    logic [128:0] obs;
    rstn = 1'b0;
    clockEdge();
    clockEdge();
    if (dutState !== {32'h0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dutState,
               {32'h0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 16'h0});
    end
    checks++;
    rstn = 1'b1;
    clockEdge();
    obs = {PCF, InstrD, PCD, PCPlus4D, ValidD};
    if (obs !== {32'd4, 32'h00A0_0093, 32'd0, 32'd4, 1'b1}) begin
      errors++;
      $display("FAIL first_fetch: got %h expected %h", obs,
               {32'd4, 32'h00A0_0093, 32'd0, 32'd4, 1'b1});
    end
    checks++;
    clockEdge();
    if (PCF !== 32'd8 || dutState !== expState) begin
      errors++;
      $display("FAIL second_fetch: got PCF %h state %h expected PCF 8 state %h", PCF, dutState, expState);
    end
    checks++;
  endtask

  task automatic test_load_use();
    StallF = 1'b1; StallD = 1'b1;
    clockEdge();
    if ({PCF, PCD} !== {32'd8, 32'd4} || dutState !== expState) begin
      errors++;
      $display("FAIL load_use_hold: got PCF %h PCD %h expected 8 4 (state %h vs %h)", PCF, PCD, dutState, expState);
    end
    checks++;
    clearCtl();
    clockEdge();
    if ({PCF, PCD} !== {32'd12, 32'd8} || dutState !== expState) begin
      errors++;
      $display("FAIL load_use_release: got PCF %h PCD %h expected c 8 (state %h vs %h)", PCF, PCD, dutState, expState);
    end
    checks++;
  endtask

  task automatic test_branch();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100; FlushD = 1'b1;
    clockEdge();
    if ({PCF, InstrD, ValidD, redirect_cnt} !== {32'h100, NOP, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL branch_redirect: got %h expected %h", {PCF, InstrD, ValidD, redirect_cnt},
               {32'h100, NOP, 1'b0, 16'd1});
    end
    checks++;
    clearCtl();
    clockEdge();
    if ({PCD, ValidD} !== {32'h100, 1'b1} || dutState !== expState) begin
      errors++;
      $display("FAIL branch_target_decode: got PCD %h ValidD %b expected 100 1 (state %h vs %h)",
               PCD, ValidD, dutState, expState);
    end
    checks++;
  endtask

  task automatic test_priority();
    PCSrcE = 1'b1; StallF = 1'b1; FlushD = 1'b1; StallD = 1'b1; PCTargetE = 32'h0000_0203;
    clockEdge();
    if ({PCF, InstrD, PCD, PCPlus4D, ValidD} !== {32'h200, NOP, 32'h0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL priority: got %h expected %h", {PCF, InstrD, PCD, PCPlus4D, ValidD},
               {32'h200, NOP, 32'h0, 32'h0, 1'b0});
    end
    checks++;
    clearCtl();
    clockEdge();
    if (dutState !== expState) begin
      errors++;
      $display("FAIL priority_after: got %h expected %h", dutState, expState);
    end
    checks++;
  endtask

  task automatic test_enable_reset();
    savedState = expState;
    en = 1'b0; PCSrcE = 1'b1; StallF = 1'b1; FlushD = 1'b1; PCTargetE = 32'h0000_0ABC;
    for (int i = 0; i < 3; i++) begin
      clockEdge();
      if (dutState !== savedState) begin
        errors++;
        $display("FAIL enable_hold cycle %0d: got %h expected %h", i, dutState, savedState);
      end
      checks++;
    end
    clearCtl();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
    clockEdge();
    if (PCF !== 32'h40 || dutState !== expState) begin
      errors++;
      $display("FAIL enable_resume: got PCF %h state %h expected PCF 40 state %h", PCF, dutState, expState);
    end
    checks++;
    PCSrcE = 1'b0; StallD = 1'b1; rstn = 1'b0;
    clockEdge();
    if ({PCF, ValidD, redirect_cnt} !== {32'h0, 1'b0, 16'h0} || dutState !== expState) begin
      errors++;
      $display("FAIL midrun_reset: got PCF %h ValidD %b cnt %h expected 0 0 0", PCF, ValidD, redirect_cnt);
    end
    checks++;
    rstn = 1'b1;
    clearCtl();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rstn      = ($urandom_range(0, 49) != 0);
      en        = ($urandom_range(0, 9) != 0);
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = ($urandom_range(0, 3) == 0);
      FlushD    = ($urandom_range(0, 5) == 0);
      PCSrcE    = ($urandom_range(0, 6) == 0);
      PCTargetE = $urandom;
      clockEdge();
      if (dutState !== expState) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, dutState, expState);
      end
      checks++;
    end
    rstn = 1'b1;
    clearCtl();
  endtask

  task automatic test_wrap_saturate();
    rstn = 1'b0;
    clockEdge();
    rstn = 1'b1;
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    clockEdge();
    if (PCF !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_preload: got PCF %h expected fffffffc", PCF);
    end
    checks++;
    PCSrcE = 1'b0;
    clockEdge();
    if (PCF !== 32'h0 || dutState !== expState) begin
      errors++;
      $display("FAIL wrap_pc: got PCF %h state %h expected PCF 0 state %h", PCF, dutState, expState);
    end
    checks++;
    if ({PCD, PCPlus4D} !== {32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_decode: got PCD %h PCPlus4D %h expected fffffffc 0", PCD, PCPlus4D);
    end
    checks++;
    PCSrcE = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      PCTargetE = $urandom;
      clockEdge();
      if (dutState !== expState) begin
        errors++;
        $display("FAIL saturate cycle %0d: got %h expected %h", i, dutState, expState);
      end
      checks++;
    end
    if (redirect_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate_final: got cnt %h expected ffff", redirect_cnt);
    end
    checks++;
    clearCtl();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_enable_reset();
    test_random();
    test_wrap_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
